// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common-data-bus arbiter.
// Fixed result value and ROB index widths.
package cdb_arbiter_pkg;

  localparam int VALUE_W   = 32;
  localparam int ROB_IDX_W = 6;

  typedef logic [3:0] nzcv_t;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [VALUE_W-1:0]   value;
    logic                 set_nzcv;
    nzcv_t                nzcv;
    logic                 is_mispred;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-side result channels and the single ROB broadcast port.
// Master drives results; slave is the arbiter.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2
);
  logic [NUM_CH-1:0]           in_fu_done;
  logic [NUM_CH*ROB_IDX_W-1:0] in_fu_dst_rob_index;
  logic [NUM_CH*VALUE_W-1:0]   in_fu_value;
  logic [NUM_CH-1:0]           in_fu_set_nzcv;
  logic [NUM_CH*4-1:0]         in_fu_nzcv;
  logic [NUM_CH-1:0]           in_fu_is_mispred;
  logic [NUM_CH-1:0]           out_fu_ready;

  logic                        out_rob_done;
  logic [ROB_IDX_W-1:0]        out_rob_dst_rob_index;
  logic [VALUE_W-1:0]          out_rob_value;
  logic                        out_rob_set_nzcv;
  nzcv_t                       out_rob_nzcv;
  logic                        out_rob_is_mispred;
  logic [$clog2(NUM_CH):0]     out_rob_src_ch;

  modport master (
    output in_fu_done, in_fu_dst_rob_index, in_fu_value,
    output in_fu_set_nzcv, in_fu_nzcv, in_fu_is_mispred,
    input  out_fu_ready,
    input  out_rob_done, out_rob_dst_rob_index, out_rob_value,
    input  out_rob_set_nzcv, out_rob_nzcv, out_rob_is_mispred,
    input  out_rob_src_ch
  );

  modport slave (
    input  in_fu_done, in_fu_dst_rob_index, in_fu_value,
    input  in_fu_set_nzcv, in_fu_nzcv, in_fu_is_mispred,
    output out_fu_ready,
    output out_rob_done, out_rob_dst_rob_index, out_rob_value,
    output out_rob_set_nzcv, out_rob_nzcv, out_rob_is_mispred,
    output out_rob_src_ch
  );
endinterface

// File: rtl/cdb_arbiter_fifo.sv
// Per-channel result FIFO; count carries an extra bit so full and
// empty stay distinct. Pushes into a full FIFO are dropped.
module cdb_arbiter_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  cdb_entry_t din,
  output logic       full,
  output logic       empty,
  output cdb_entry_t head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  cdb_entry_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (pop)     rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(pop);
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: N FU FIFOs into one registered ROB broadcast.
// Define CDB_MISPRED_PRIORITY_EN to let mispredict heads jump the queue.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 2
) (
  input logic          in_clk,
  input logic          in_rst,
  cdb_arbiter_if.slave bus
);
  localparam int CW = $clog2(NUM_CH) + 1;

  cdb_entry_t        push_e [NUM_CH];
  cdb_entry_t        head   [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign push_e[g] = '{
      rob_idx:    bus.in_fu_dst_rob_index[g*ROB_IDX_W +: ROB_IDX_W],
      value:      bus.in_fu_value[g*VALUE_W +: VALUE_W],
      set_nzcv:   bus.in_fu_set_nzcv[g],
      nzcv:       bus.in_fu_nzcv[g*4 +: 4],
      is_mispred: bus.in_fu_is_mispred[g]
    };

    cdb_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (in_clk),
      .rst   (in_rst),
      .push  (bus.in_fu_done[g]),
      .pop   (pop[g]),
      .din   (push_e[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (head[g])
    );
  end

  assign bus.out_fu_ready = ~full;

  logic [CW-1:0] rr;
  logic [CW-1:0] gnt;
  logic [CW-1:0] rr_nxt;
  logic          gnt_v;
  cdb_entry_t    sel;

  always_comb begin
    int j;
    j     = 0;
    gnt_v = 1'b0;
    gnt   = '0;
    sel   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(rr) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!gnt_v && !empty[j]) begin
        gnt_v = 1'b1;
        gnt   = CW'(j);
        sel   = head[j];
      end
    end
`ifdef CDB_MISPRED_PRIORITY_EN
    // descending scan so the lowest mispredicting channel wins
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!empty[i] && head[i].is_mispred) begin
        gnt_v = 1'b1;
        gnt   = CW'(i);
        sel   = head[i];
      end
    end
`endif
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++)
      pop[i] = gnt_v && (gnt == CW'(i));
  end

  assign rr_nxt = (int'(gnt) + 1 >= NUM_CH) ? '0 : gnt + CW'(1);

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      rr                        <= '0;
      bus.out_rob_done          <= 1'b0;
      bus.out_rob_dst_rob_index <= '0;
      bus.out_rob_value         <= '0;
      bus.out_rob_set_nzcv      <= 1'b0;
      bus.out_rob_nzcv          <= '0;
      bus.out_rob_is_mispred    <= 1'b0;
      bus.out_rob_src_ch        <= '0;
    end else if (gnt_v) begin
      rr                        <= rr_nxt;
      bus.out_rob_done          <= 1'b1;
      bus.out_rob_dst_rob_index <= sel.rob_idx;
      bus.out_rob_value         <= sel.value;
      bus.out_rob_set_nzcv      <= sel.set_nzcv;
      bus.out_rob_nzcv          <= sel.nzcv;
      bus.out_rob_is_mispred    <= sel.is_mispred;
      bus.out_rob_src_ch        <= gnt;
    end else begin
      bus.out_rob_done          <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter (NUM_CH=2, FIFO_DEPTH=2).
// Mispredict ordering expectations follow CDB_MISPRED_PRIORITY_EN.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NUM_CH     = 2;
  localparam int FIFO_DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

  cdb_arbiter #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .in_clk (clk),
    .in_rst (rst),
    .bus    (bus)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  int         seq    = 0;
  cdb_entry_t sb0 [$];
  cdb_entry_t sb1 [$];
  int         seen [$];
  cdb_entry_t mon_got;
  cdb_entry_t mon_exp;
  logic       mon_ok;

  function automatic cdb_entry_t mk(input int ch, input logic mp);
    cdb_entry_t e;
    seq++;
    e.rob_idx    = ROB_IDX_W'(seq);
    e.value      = VALUE_W'($urandom) ^ VALUE_W'(ch);
    e.set_nzcv   = seq[0];
    e.nzcv       = nzcv_t'(seq);
    e.is_mispred = mp;
    return e;
  endfunction

  task automatic set_ch(input int ch, input cdb_entry_t e);
    bus.in_fu_dst_rob_index[ch*ROB_IDX_W +: ROB_IDX_W] = e.rob_idx;
    bus.in_fu_value[ch*VALUE_W +: VALUE_W]             = e.value;
    bus.in_fu_set_nzcv[ch]                             = e.set_nzcv;
    bus.in_fu_nzcv[ch*4 +: 4]                          = e.nzcv;
    bus.in_fu_is_mispred[ch]                           = e.is_mispred;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle(input logic [1:0] d, input cdb_entry_t e0,
                             input cdb_entry_t e1, output logic [1:0] acc);
    acc = d & bus.out_fu_ready;
    set_ch(0, e0);
    set_ch(1, e1);
    bus.in_fu_done = acc;
    if (acc[0]) sb0.push_back(e0);
    if (acc[1]) sb1.push_back(e1);
    step();
    bus.in_fu_done = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_fu_done = '0;
    step();
    step();
    sb0.delete();
    sb1.delete();
    seen.delete();
    rst = 1'b1;
    step();
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 20 && (sb0.size() + sb1.size()) > 0; c++) step();
    step();
    step();
    n_chk++;
    if ((sb0.size() + sb1.size()) !== 0) begin
      n_fail++;
      $display("FAIL %s_drain: pending=%0d required=0", name,
               sb0.size() + sb1.size());
    end
  endtask

  // scoreboard: every broadcast must match the oldest entry of its channel
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.out_rob_done === 1'b1) begin
      mon_got.rob_idx    = bus.out_rob_dst_rob_index;
      mon_got.value      = bus.out_rob_value;
      mon_got.set_nzcv   = bus.out_rob_set_nzcv;
      mon_got.nzcv       = bus.out_rob_nzcv;
      mon_got.is_mispred = bus.out_rob_is_mispred;
      seen.push_back(int'(bus.out_rob_src_ch));
      mon_ok = 1'b1;
      if (bus.out_rob_src_ch === 0 && sb0.size() > 0) mon_exp = sb0.pop_front();
      else if (bus.out_rob_src_ch === 1 && sb1.size() > 0) mon_exp = sb1.pop_front();
      else mon_ok = 1'b0;
      n_chk++;
      if (!mon_ok) begin
        n_fail++;
        $display("FAIL bcast_unexpected: src=%0d entry=%h required=no broadcast",
                 bus.out_rob_src_ch, mon_got);
      end else if (mon_got !== mon_exp) begin
        n_fail++;
        $display("FAIL bcast_data: src=%0d got=%h required=%h",
                 bus.out_rob_src_ch, mon_got, mon_exp);
      end
    end
  end

  always @(posedge clk) begin
    if (rst === 1'b1 && (bus.in_fu_done & ~bus.out_fu_ready) != '0) begin
      n_fail++;
      $display("FAIL protocol_push_full: done=%b ready=%b",
               bus.in_fu_done, bus.out_fu_ready);
    end
  end

  task automatic check_seq(input string name, input int exp[$]);
    n_chk++;
    if (seen.size() !== exp.size()) begin
      n_fail++;
      $display("FAIL %s_count: got=%0d required=%0d", name, seen.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_chk++;
        if (seen[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL %s_order[%0d]: got ch%0d required ch%0d", name, i, seen[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_ch(0, mk(0, 1'b0));
    set_ch(1, mk(1, 1'b0));
    bus.in_fu_done = 2'b11;
    step();
    step();
    bus.in_fu_done = '0;
    n_chk++;
    if (bus.out_rob_done !== 1'b0 || bus.out_rob_value !== '0 ||
        bus.out_rob_dst_rob_index !== '0 || bus.out_rob_src_ch !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: done=%b idx=%0d val=%h src=%0d required all 0",
               bus.out_rob_done, bus.out_rob_dst_rob_index, bus.out_rob_value,
               bus.out_rob_src_ch);
    end
    n_chk++;
    if (bus.out_fu_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ready: got=%b required=11", bus.out_fu_ready);
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_chk++;
      if (bus.out_rob_done !== 1'b0 || bus.out_fu_ready !== 2'b11) begin
        n_fail++;
        $display("FAIL reset_idle: done=%b ready=%b required done=0 ready=11",
                 bus.out_rob_done, bus.out_fu_ready);
      end
    end
  endtask

  task automatic test_single();
    cdb_entry_t e;
    logic [1:0] acc;
    do_reset();
    e = '{rob_idx: ROB_IDX_W'(3), value: VALUE_W'(32'hfff), set_nzcv: 1'b1,
          nzcv: 4'b1010, is_mispred: 1'b0};
    drive_cycle(2'b01, e, mk(1, 1'b0), acc);
    n_chk++;
    if (bus.out_rob_done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_bypass: done=%b required=0", bus.out_rob_done);
    end
    step();
    n_chk++;
    if (bus.out_rob_done !== 1'b1 || bus.out_rob_dst_rob_index !== ROB_IDX_W'(3) ||
        bus.out_rob_value !== VALUE_W'(32'hfff) || bus.out_rob_src_ch !== '0) begin
      n_fail++;
      $display("FAIL single_bcast: done=%b idx=%0d val=%h src=%0d required 1/3/fff/0",
               bus.out_rob_done, bus.out_rob_dst_rob_index, bus.out_rob_value,
               bus.out_rob_src_ch);
    end
    step();
    n_chk++;
    if (bus.out_rob_done !== 1'b0 || bus.out_rob_dst_rob_index !== ROB_IDX_W'(3)) begin
      n_fail++;
      $display("FAIL single_pulse_hold: done=%b idx=%0d required done=0 idx=3",
               bus.out_rob_done, bus.out_rob_dst_rob_index);
    end
  endtask

  task automatic test_back_to_back();
    int p0, p1;
    logic dropped;
    logic [1:0] acc;
    int exp[$];
    do_reset();
    p0 = 0;
    p1 = 0;
    dropped = 1'b0;
    for (int c = 0; c < 20 && (p0 < 4 || p1 < 4); c++) begin
      if (bus.out_fu_ready !== 2'b11) dropped = 1'b1;
      drive_cycle({p1 < 4, p0 < 4}, mk(0, 1'b0), mk(1, 1'b0), acc);
      p0 += int'(acc[0]);
      p1 += int'(acc[1]);
    end
    drain("b2b");
    n_chk++;
    if (dropped !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_drop: got=%b required=1", dropped);
    end
    for (int i = 0; i < 8; i++) exp.push_back(i % 2);
    check_seq("b2b", exp);
  endtask

  task automatic test_rr_order();
    logic [1:0] acc;
    do_reset();
    drive_cycle(2'b01, mk(0, 1'b0), mk(1, 1'b0), acc);
    drive_cycle(2'b11, mk(0, 1'b0), mk(1, 1'b0), acc);
    drain("rr");
    check_seq("rr", '{0, 1, 0});
    seen.delete();
    drive_cycle(2'b11, mk(0, 1'b0), mk(1, 1'b0), acc);
    drain("rr_ptr");
    check_seq("rr_ptr", '{1, 0});
  endtask

  task automatic test_mispred();
    logic [1:0] acc;
    do_reset();
    drive_cycle(2'b11, mk(0, 1'b0), mk(1, 1'b0), acc);
    drive_cycle(2'b11, mk(0, 1'b0), mk(1, 1'b1), acc);
    drive_cycle(2'b01, mk(0, 1'b0), mk(1, 1'b0), acc);
    drain("mp");
`ifdef CDB_MISPRED_PRIORITY_EN
    check_seq("mp", '{0, 1, 1, 0, 0});
`else
    check_seq("mp", '{0, 1, 0, 1, 0});
`endif
  endtask

  task automatic test_reset_flush();
    logic [1:0] acc;
    do_reset();
    for (int c = 0; c < 3; c++)
      drive_cycle(2'b11, mk(0, 1'b0), mk(1, 1'b0), acc);
    rst = 1'b0;
    step();
    sb0.delete();
    sb1.delete();
    n_chk++;
    if (bus.out_rob_done !== 1'b0 || bus.out_fu_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL flush_in_reset: done=%b ready=%b required done=0 ready=11",
               bus.out_rob_done, bus.out_fu_ready);
    end
    step();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_chk++;
      if (bus.out_rob_done !== 1'b0 || bus.out_fu_ready !== 2'b11) begin
        n_fail++;
        $display("FAIL flush_after: done=%b ready=%b required done=0 ready=11",
                 bus.out_rob_done, bus.out_fu_ready);
      end
    end
  endtask

  initial begin
    bus.in_fu_done          = '0;
    bus.in_fu_dst_rob_index = '0;
    bus.in_fu_value         = '0;
    bus.in_fu_set_nzcv      = '0;
    bus.in_fu_nzcv          = '0;
    bus.in_fu_is_mispred    = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_rr_order();
    test_mispred();
    test_reset_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
